// File: rtl/gb_intc_pkg.sv
// Shared constants, source indices and dispatch state encoding for the
// interrupt controller (register map, vector generation).
package gb_intc_pkg;

    localparam logic [15:0] ADDR_IF       = 16'hFF0F;
    localparam logic [15:0] ADDR_IE       = 16'hFFFF;
    localparam logic [7:0]  VECTOR_BASE   = 8'h40;
    localparam int          VECTOR_STRIDE = 8;

    localparam int NUM_IRQ    = 5;
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_ERR  = 2'd2
    } intc_state_e;

    function automatic logic [7:0] vector_of(input logic [2:0] idx);
        return VECTOR_BASE + 8'(VECTOR_STRIDE) * {5'd0, idx};
    endfunction

endpackage

// File: rtl/intc_priority_enc.sv
// Fixed-priority encoder: lowest set bit wins (bit0 = VBlank highest).
module intc_priority_enc
    import gb_intc_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [2:0]         idx,
    output logic               valid
);

    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        // Descending scan so the lowest index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE registers, IME and dispatch FSM with vector generation.
// Optional macro INTC_EI_DELAY_EN delays EI until after the following instruction.
//
// state   | meaning
// ST_IDLE | waiting for a dispatch strobe
// ST_ACK  | dispatch just taken, further strobes ignored this cycle
// ST_ERR  | illegal encoding, recovers to ST_IDLE
module interrupt_controller
    import gb_intc_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [4:0]  i_Irq,
    input  logic [15:0] i_Addr,
    input  logic [7:0]  i_Data,
    input  logic        i_Write,
    input  logic        i_Read,
    output logic [7:0]  o_Data,
    output logic        o_Data_Valid,
    input  logic        i_EI,
    input  logic        i_DI,
    input  logic        i_RETI,
    input  logic        i_Instr_Boundary,
    output logic [4:0]  o_Interrupts,
    output logic        o_Irq_Req,
    output logic        o_Wake,
    input  logic        i_Ack,
    output logic [7:0]  o_Vector
);

    logic [4:0]  if_q, if_n, clr_mask, pend;
    logic [7:0]  ie_q, vector_q;
    logic        ime_q, ime_n;
    logic [2:0]  pend_idx;
    logic        pend_valid, dispatch, wr_if, wr_ie;
    intc_state_e state_q, state_n;

    assign pend  = if_q & ie_q[4:0];
    assign wr_if = i_Write && (i_Addr == ADDR_IF);
    assign wr_ie = i_Write && (i_Addr == ADDR_IE);

    intc_priority_enc u_enc (
        .req   (pend),
        .idx   (pend_idx),
        .valid (pend_valid)
    );

    always_comb begin
        state_n  = state_q;
        dispatch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Ack) begin
                    state_n  = ST_ACK;
                    dispatch = 1'b1;
                end
            end
            ST_ACK:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Incoming requests are OR-ed last so they win over writes and dispatch clears.
    always_comb begin
        clr_mask = (dispatch && pend_valid) ? 5'(5'b00001 << pend_idx) : 5'b00000;
        if_n     = ((wr_if ? i_Data[4:0] : if_q) & ~clr_mask) | i_Irq;
    end

`ifdef INTC_EI_DELAY_EN
    logic       ei_pend_q, ei_pend_n;
    logic [1:0] ei_cnt_q, ei_cnt_n;

    always_comb begin
        ime_n     = ime_q;
        ei_pend_n = ei_pend_q;
        ei_cnt_n  = ei_cnt_q;
        if (i_EI && !ei_pend_q) begin
            ei_pend_n = 1'b1;
            ei_cnt_n  = 2'd2;
        end else if (ei_pend_q && i_Instr_Boundary) begin
            if (ei_cnt_q == 2'd1) begin
                ime_n     = 1'b1;
                ei_pend_n = 1'b0;
            end
            ei_cnt_n = ei_cnt_q - 2'd1;
        end
        if (i_RETI) ime_n = 1'b1;
        if (i_DI) begin
            ime_n     = 1'b0;
            ei_pend_n = 1'b0;
        end
        if (dispatch) ime_n = 1'b0;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            ei_pend_q <= 1'b0;
            ei_cnt_q  <= 2'd0;
        end else begin
            ei_pend_q <= ei_pend_n;
            ei_cnt_q  <= ei_cnt_n;
        end
    end
`else
    logic unused_boundary;
    assign unused_boundary = i_Instr_Boundary;

    always_comb begin
        ime_n = ime_q;
        if (i_EI || i_RETI) ime_n = 1'b1;
        if (i_DI)           ime_n = 1'b0;
        if (dispatch)       ime_n = 1'b0;
    end
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            if_q     <= 5'd0;
            ie_q     <= 8'h00;
            ime_q    <= 1'b0;
            vector_q <= 8'h00;
            state_q  <= ST_IDLE;
        end else begin
            if_q    <= if_n;
            ime_q   <= ime_n;
            state_q <= state_n;
            if (wr_ie)    ie_q     <= i_Data;
            if (dispatch) vector_q <= pend_valid ? vector_of(pend_idx) : 8'h00;
        end
    end

    always_comb begin
        o_Data       = 8'h00;
        o_Data_Valid = 1'b0;
        if (i_Read) begin
            if (i_Addr == ADDR_IF) begin
                o_Data       = {3'b111, if_q};
                o_Data_Valid = 1'b1;
            end else if (i_Addr == ADDR_IE) begin
                o_Data       = ie_q;
                o_Data_Valid = 1'b1;
            end
        end
    end

    assign o_Interrupts = pend;
    assign o_Wake       = |pend;
    assign o_Irq_Req    = ime_q & (|pend);
    assign o_Vector     = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  irq;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr, rd;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        ei, di, reti, boundary, ack;
    logic [4:0]  ints;
    logic        irq_req, wake;
    logic [7:0]  vector;

    int errors = 0;
    int checks = 0;

    interrupt_controller dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_Irq            (irq),
        .i_Addr           (addr),
        .i_Data           (wdata),
        .i_Write          (wr),
        .i_Read           (rd),
        .o_Data           (rdata),
        .o_Data_Valid     (rvalid),
        .i_EI             (ei),
        .i_DI             (di),
        .i_RETI           (reti),
        .i_Instr_Boundary (boundary),
        .o_Interrupts     (ints),
        .o_Irq_Req        (irq_req),
        .o_Wake           (wake),
        .i_Ack            (ack),
        .o_Vector         (vector)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [7:0] d, output logic v);
        addr = a; rd = 1'b1;
        #1;
        d = rdata; v = rvalid;
        rd = 1'b0;
        #1;
    endtask

    task automatic strobe_reti();
        reti = 1'b1; tick(); reti = 1'b0;
    endtask

    task automatic strobe_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v;
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (ints !== 5'd0) begin errors++; $display("FAIL reset_ints: got %h want 00", ints); end
        checks++; if (irq_req !== 1'b0 || wake !== 1'b0) begin errors++; $display("FAIL reset_req_wake: got %b%b want 00", irq_req, wake); end
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h want 00", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE0 || v !== 1'b1) begin errors++; $display("FAIL reset_if_read: got %h/%b want e0/1", d, v); end
        read_reg(16'hFFFF, d, v);
        checks++; if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL reset_ie_read: got %h/%b want 00/1", d, v); end
        read_reg(16'h1234, d, v);
        checks++; if (d !== 8'h00 || v !== 1'b0) begin errors++; $display("FAIL other_addr_read: got %h/%b want 00/0", d, v); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timer_dispatch();
        logic [7:0] d; logic v;
        write_reg(16'hFFFF, 8'h05);
        strobe_reti();
        irq = 5'b00100; tick(); irq = 5'd0;
        checks++; if (ints !== 5'b00100) begin errors++; $display("FAIL timer_ints: got %b want 00100", ints); end
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL timer_req: got %b want 1", irq_req); end
        strobe_ack();
        checks++; if (vector !== 8'h50) begin errors++; $display("FAIL timer_vector: got %h want 50", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE0) begin errors++; $display("FAIL timer_if_clear: got %h want e0", d); end
        irq = 5'b00001; tick(); irq = 5'd0;
        checks++; if (wake !== 1'b1 || irq_req !== 1'b0) begin errors++; $display("FAIL timer_ime_clear: wake/req got %b%b want 10", wake, irq_req); end
        write_reg(16'hFF0F, 8'h00);
    endtask

    task automatic test_priority();
        logic [7:0] d; logic v;
        write_reg(16'hFF0F, 8'h1F);
        write_reg(16'hFFFF, 8'h1F);
        strobe_reti();
        strobe_ack();
        checks++; if (vector !== 8'h40) begin errors++; $display("FAIL prio_vec0: got %h want 40", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hFE) begin errors++; $display("FAIL prio_if0: got %h want fe", d); end
        strobe_reti();
        strobe_ack();
        checks++; if (vector !== 8'h48) begin errors++; $display("FAIL prio_vec1: got %h want 48", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hFC) begin errors++; $display("FAIL prio_if1: got %h want fc", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic v;
        write_reg(16'hFF0F, 8'h1C);
        ack = 1'b1;
        tick();
        checks++; if (vector !== 8'h50) begin errors++; $display("FAIL b2b_first: got %h want 50", vector); end
        tick();
        checks++; if (vector !== 8'h50) begin errors++; $display("FAIL b2b_ignored_vec: got %h want 50", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hF8) begin errors++; $display("FAIL b2b_ignored_if: got %h want f8", d); end
        tick();
        ack = 1'b0;
        checks++; if (vector !== 8'h58) begin errors++; $display("FAIL b2b_third: got %h want 58", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL b2b_third_if: got %h want f0", d); end
    endtask

    task automatic test_wake();
        logic [7:0] d; logic v;
        write_reg(16'hFF0F, 8'h00);
        write_reg(16'hFFFF, 8'h10);
        irq = 5'b10000; tick(); irq = 5'd0;
        checks++; if (wake !== 1'b1 || irq_req !== 1'b0) begin errors++; $display("FAIL wake_no_ime: wake/req got %b%b want 10", wake, irq_req); end
        checks++; if (ints !== 5'b10000) begin errors++; $display("FAIL wake_ints: got %b want 10000", ints); end
        strobe_ack();
        checks++; if (vector !== 8'h60) begin errors++; $display("FAIL wake_vector: got %h want 60", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE0) begin errors++; $display("FAIL wake_if: got %h want e0", d); end
    endtask

    task automatic test_write_race();
        logic [7:0] d; logic v;
        addr = 16'hFF0F; wdata = 8'h00; wr = 1'b1; irq = 5'b00010;
        tick();
        wr = 1'b0; irq = 5'd0;
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE2) begin errors++; $display("FAIL write_race_if: got %h want e2", d); end
        write_reg(16'hFFFF, 8'h00);
        strobe_ack();
        checks++; if (vector !== 8'h00) begin errors++; $display("FAIL empty_ack_vector: got %h want 00", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE2) begin errors++; $display("FAIL empty_ack_if: got %h want e2", d); end
    endtask

    task automatic test_ack_race();
        logic [7:0] d; logic v;
        write_reg(16'hFF0F, 8'h01);
        write_reg(16'hFFFF, 8'h01);
        ack = 1'b1; irq = 5'b00001;
        tick();
        ack = 1'b0; irq = 5'd0;
        checks++; if (vector !== 8'h40) begin errors++; $display("FAIL ack_race_vec: got %h want 40", vector); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE1) begin errors++; $display("FAIL ack_race_if: got %h want e1", d); end
        tick();
    endtask

    task automatic test_ime();
        // IF bit0 and IE bit0 are left set by the previous test.
        di = 1'b1; tick(); di = 1'b0;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL di_clear: got %b want 0", irq_req); end
        strobe_reti();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL reti_set: got %b want 1", irq_req); end
        di = 1'b1; tick(); di = 1'b0;
`ifdef INTC_EI_DELAY_EN
        ei = 1'b1; tick(); ei = 1'b0;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ei_delay_0: got %b want 0", irq_req); end
        boundary = 1'b1; tick(); boundary = 1'b0;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ei_delay_1: got %b want 0", irq_req); end
        boundary = 1'b1; tick(); boundary = 1'b0;
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL ei_delay_2: got %b want 1", irq_req); end
        di = 1'b1; tick(); di = 1'b0;
        ei = 1'b1; tick(); ei = 1'b0;
        boundary = 1'b1; tick(); boundary = 1'b0;
        di = 1'b1; tick(); di = 1'b0;
        boundary = 1'b1; tick(); tick(); boundary = 1'b0;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ei_cancel: got %b want 0", irq_req); end
        ei = 1'b1; tick(); ei = 1'b0;
        boundary = 1'b1; tick(); boundary = 1'b0;
        ei = 1'b1; tick(); ei = 1'b0;
        boundary = 1'b1; tick(); boundary = 1'b0;
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL ei_no_restart: got %b want 1", irq_req); end
`else
        ei = 1'b1; tick(); ei = 1'b0;
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL ei_immediate: got %b want 1", irq_req); end
`endif
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] d; logic v;
        write_reg(16'hFF0F, 8'h1F);
        write_reg(16'hFFFF, 8'h1F);
        strobe_ack();
        checks++; if (vector !== 8'h40) begin errors++; $display("FAIL mid_ack_vec: got %h want 40", vector); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (vector !== 8'h00 || ints !== 5'd0) begin errors++; $display("FAIL mid_ack_reset: vec %h ints %b want 00 00000", vector, ints); end
        read_reg(16'hFF0F, d, v);
        checks++; if (d !== 8'hE0) begin errors++; $display("FAIL mid_ack_if: got %h want e0", d); end
        read_reg(16'hFFFF, d, v);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_ack_ie: got %h want 00", d); end
        write_reg(16'hFFFF, 8'h08);
        irq = 5'b01000; tick(); irq = 5'd0;
        strobe_ack();
        checks++; if (vector !== 8'h58) begin errors++; $display("FAIL post_reset_ack: got %h want 58", vector); end
    endtask

    initial begin
        rst_n = 1'b0; irq = 5'd0; addr = 16'h0000; wdata = 8'h00;
        wr = 1'b0; rd = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
        boundary = 1'b0; ack = 1'b0;
        test_reset();
        test_timer_dispatch();
        test_priority();
        test_back_to_back();
        test_wake();
        test_write_race();
        test_ack_race();
        test_ime();
        test_reset_mid_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
